// File: rtl/coldstorage_pkg.sv
// Shared definitions for the cold-storage controller: ASCII command set,
// command parser state encoding and byte classification helpers.
package coldstorage_pkg;

   localparam logic [7:0] CMD_TMAX = 8'h54;  // 'T'
   localparam logic [7:0] CMD_TMIN = 8'h74;  // 't'
   localparam logic [7:0] CMD_HMAX = 8'h48;  // 'H'
   localparam logic [7:0] CMD_HMIN = 8'h68;  // 'h'
   localparam logic [7:0] CMD_FAN  = 8'h46;  // 'F'
   localparam logic [7:0] CMD_HUM  = 8'h66;  // 'f'
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_CR   = 8'h0D;
   localparam logic [7:0] ASC_0    = 8'h30;

   typedef enum logic [1:0] {
      IDLE,
      GOT_CMD,
      GOT_D0,
      GOT_D1
   } parser_state_t;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_TMAX) || (b == CMD_TMIN) || (b == CMD_HMAX) ||
             (b == CMD_HMIN) || (b == CMD_FAN)  || (b == CMD_HUM);
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASC_0) && (b <= (ASC_0 + 8'd9));
   endfunction

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASC_LF) || (b == ASC_CR);
   endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART receiver plus the decoded command outputs.
interface uart_cmd_parser_if #(
   parameter int unsigned ERR_CNT_W = 8
);
   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic [7:0]           chr_cmd;
   logic [7:0]           chr_val0;
   logic [7:0]           chr_val1;
   logic [6:0]           val_bin;
   logic                 rx_msg_done;
   logic                 frame_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output rx_data, rx_valid,
      input  chr_cmd, chr_val0, chr_val1, val_bin, rx_msg_done, frame_err, err_cnt
   );

   modport slave (
      input  rx_data, rx_valid,
      output chr_cmd, chr_val0, chr_val1, val_bin, rx_msg_done, frame_err, err_cnt
   );
endinterface

// File: rtl/timeout_timer.sv
// Free-running gap counter: clears on clr, counts while en, and pulses
// expire combinationally on the last count of the window.
module timeout_timer #(
   parameter int unsigned CYCLES = 5_000_000,
   parameter int unsigned W      = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt;

   // clr has priority so a byte landing on the expiry cycle never times out
   assign expire = en && !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= '0;
      else if (clr || expire)   cnt <= '0;
      else if (en)              cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles CMD,D0,D1,TERM frames from the UART byte stream, commits good
// frames to the output registers and flags malformed or stalled ones.
module uart_cmd_parser
   import coldstorage_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned TIMEOUT_MS  = 50,
   parameter int unsigned ERR_CNT_W   = 8
) (
   input logic               clk,
   input logic               rst_n,
   uart_cmd_parser_if.slave  bus
);
   localparam int unsigned          TIMEOUT_CYC = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
   localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

   parser_state_t state, state_nxt;
   logic [7:0]    sh_cmd, sh_d0, sh_d1;
   logic          ld_cmd, ld_d0, ld_d1, commit, err, bad, expire;
   logic          tmr_clr, tmr_en;
   logic [7:0]    b;

   assign b       = bus.rx_data;
   assign tmr_clr = bus.rx_valid || (state == IDLE);
   assign tmr_en  = (state != IDLE);

   timeout_timer #(.CYCLES(TIMEOUT_CYC)) u_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_cmd    = 1'b0;
      ld_d0     = 1'b0;
      ld_d1     = 1'b0;
      commit    = 1'b0;
      err       = 1'b0;
      bad       = 1'b0;
      if (bus.rx_valid) begin
         case (state)
            IDLE: begin
               if (is_cmd(b)) begin
                  state_nxt = GOT_CMD;
                  ld_cmd    = 1'b1;
               end
            end
            GOT_CMD: begin
               if (is_digit(b)) begin
                  state_nxt = GOT_D0;
                  ld_d0     = 1'b1;
               end else bad = 1'b1;
            end
            GOT_D0: begin
               if (is_digit(b)) begin
                  state_nxt = GOT_D1;
                  ld_d1     = 1'b1;
               end else bad = 1'b1;
            end
            GOT_D1: begin
               if (is_term(b)) begin
                  state_nxt = IDLE;
                  commit    = 1'b1;
               end else bad = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
         // A command byte inside a broken frame starts a fresh one
         if (bad) begin
            err = 1'b1;
            if (is_cmd(b)) begin
               state_nxt = GOT_CMD;
               ld_cmd    = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
      end else if (expire) begin
         err       = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_cmd <= 8'h00;
         sh_d0  <= 8'h00;
         sh_d1  <= 8'h00;
      end else begin
         if (ld_cmd) sh_cmd <= b;
         if (ld_d0)  sh_d0  <= b;
         if (ld_d1)  sh_d1  <= b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.chr_cmd     <= 8'h00;
         bus.chr_val0    <= 8'h00;
         bus.chr_val1    <= 8'h00;
         bus.val_bin     <= 7'd0;
         bus.rx_msg_done <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.err_cnt     <= '0;
      end else begin
         bus.rx_msg_done <= commit;
         bus.frame_err   <= err;
         if (commit) begin
            bus.chr_cmd  <= sh_cmd;
            bus.chr_val0 <= sh_d0;
            bus.chr_val1 <= sh_d1;
            // low nibble of an ASCII digit is its value
            bus.val_bin  <= 7'(sh_d0[3:0]) * 7'd10 + 7'(sh_d1[3:0]);
         end
         if (err && (bus.err_cnt != ERR_MAX)) bus.err_cnt <= bus.err_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a frame-level reference model
// compared every cycle, plus literal checkpoints after each scenario.
module tb_uart_cmd_parser;
   localparam int CLK_HZ = 100_000;
   localparam int TMO_MS = 1;
   localparam int TO     = CLK_HZ / 1000 * TMO_MS;
   localparam int ERR_W  = 8;
   localparam int ERR_SAT = (1 << ERR_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_pass = 0;

   uart_cmd_parser_if #(.ERR_CNT_W(ERR_W)) bus ();

   uart_cmd_parser #(.CLK_FREQ_HZ(CLK_HZ), .TIMEOUT_MS(TMO_MS), .ERR_CNT_W(ERR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic bit m_cmd(input logic [7:0] x);
      return x inside {8'h54, 8'h74, 8'h48, 8'h68, 8'h46, 8'h66};
   endfunction

   function automatic bit m_dig(input logic [7:0] x);
      return (x >= 8'h30) && (x <= 8'h39);
   endfunction

   // Frame model: bytes of the frame in progress plus idle cycles since the last byte
   logic [7:0] e_cmd = 8'h00, e_v0 = 8'h00, e_v1 = 8'h00;
   int         e_val = 0, e_cnt = 0;
   bit         e_done = 0, e_err = 0;

   initial begin : model
      logic [7:0] frm[$];
      logic [7:0] b;
      int idle_n;
      idle_n = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            frm.delete();
            idle_n = 0;
            e_cmd = 8'h00; e_v0 = 8'h00; e_v1 = 8'h00;
            e_val = 0; e_cnt = 0; e_done = 0; e_err = 0;
         end else begin
            e_done = 0;
            e_err  = 0;
            if (bus.rx_valid) begin
               b = bus.rx_data;
               idle_n = 0;
               if (frm.size() == 0) begin
                  if (m_cmd(b)) frm.push_back(b);
               end else if (frm.size() < 3 && m_dig(b)) begin
                  frm.push_back(b);
               end else if (frm.size() == 3 && (b == 8'h0A || b == 8'h0D)) begin
                  e_done = 1;
                  e_cmd  = frm[0];
                  e_v0   = frm[1];
                  e_v1   = frm[2];
                  e_val  = (int'(frm[1]) - 48) * 10 + (int'(frm[2]) - 48);
                  frm.delete();
               end else begin
                  e_err = 1;
                  frm.delete();
                  if (m_cmd(b)) frm.push_back(b);
               end
            end else if (frm.size() != 0) begin
               idle_n++;
               if (idle_n == TO) begin
                  e_err = 1;
                  frm.delete();
               end
            end
            if (e_err && e_cnt < ERR_SAT) e_cnt++;
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("cyc_chr_cmd",  int'(bus.chr_cmd),     int'(e_cmd));
         chk("cyc_chr_val0", int'(bus.chr_val0),    int'(e_v0));
         chk("cyc_chr_val1", int'(bus.chr_val1),    int'(e_v1));
         chk("cyc_val_bin",  int'(bus.val_bin),     e_val);
         chk("cyc_done",     int'(bus.rx_msg_done), int'(e_done));
         chk("cyc_err",      int'(bus.frame_err),   int'(e_err));
         chk("cyc_err_cnt",  int'(bus.err_cnt),     e_cnt);
         if (bus.rx_msg_done && bus.frame_err) chk("cyc_exclusive", 1, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x, input int gap);
      bus.rx_valid = 1'b1;
      bus.rx_data  = x;
      tick();
      bus.rx_valid = 1'b0;
      repeat (gap) tick();
   endtask

   initial begin : stim
      rst_n = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) tick();
      chk("rst_chr_cmd", int'(bus.chr_cmd), 0);
      chk("rst_val_bin", int'(bus.val_bin), 0);
      chk("rst_err_cnt", int'(bus.err_cnt), 0);
      rst_n = 1'b1;
      tick();

      send(8'h54, 10); send(8'h32, 10); send(8'h35, 10); send(8'h0A, 0);
      chk("t25_done", int'(bus.rx_msg_done), 1);
      chk("t25_cmd",  int'(bus.chr_cmd), 8'h54);
      chk("t25_v0",   int'(bus.chr_val0), 8'h32);
      chk("t25_v1",   int'(bus.chr_val1), 8'h35);
      chk("t25_val",  int'(bus.val_bin), 25);
      chk("t25_err",  int'(bus.frame_err), 0);
      repeat (3) tick();

      send(8'h68, 0); send(8'h30, 0); send(8'h37, 0); send(8'h0D, 0);
      chk("h07_done", int'(bus.rx_msg_done), 1);
      chk("h07_val",  int'(bus.val_bin), 7);
      send(8'h48, 0); send(8'h39, 0); send(8'h39, 0); send(8'h0A, 0);
      chk("h99_done", int'(bus.rx_msg_done), 1);
      chk("h99_cmd",  int'(bus.chr_cmd), 8'h48);
      chk("h99_val",  int'(bus.val_bin), 99);
      repeat (3) tick();

      send(8'h54, 0); send(8'h32, 0); send(8'h78, 0);
      chk("bad_err",  int'(bus.frame_err), 1);
      chk("bad_cnt",  int'(bus.err_cnt), 1);
      chk("bad_hold", int'(bus.val_bin), 99);
      send(8'h0A, 0);
      chk("bad_term_done", int'(bus.rx_msg_done), 0);
      chk("bad_term_err",  int'(bus.frame_err), 0);
      repeat (3) tick();

      send(8'h54, 0); send(8'h33, 0); send(8'h48, 0);
      chk("resync_err",  int'(bus.frame_err), 1);
      chk("resync_done", int'(bus.rx_msg_done), 0);
      chk("resync_cnt",  int'(bus.err_cnt), 2);
      send(8'h34, 0); send(8'h30, 0); send(8'h0A, 0);
      chk("resync_commit", int'(bus.rx_msg_done), 1);
      chk("resync_cmd",    int'(bus.chr_cmd), 8'h48);
      chk("resync_val",    int'(bus.val_bin), 40);
      repeat (3) tick();

      send(8'h46, 0); send(8'h31, 0);
      repeat (TO - 1) tick();
      chk("tmo_early", int'(bus.frame_err), 0);
      tick();
      chk("tmo_err", int'(bus.frame_err), 1);
      chk("tmo_cnt", int'(bus.err_cnt), 3);
      send(8'h32, 0); send(8'h0A, 0);
      chk("tmo_idle_after", int'(bus.rx_msg_done), 0);
      repeat (3) tick();

      send(8'h46, 0); send(8'h31, 0);
      repeat (TO - 1) tick();
      send(8'h32, 0);
      chk("edge_no_err", int'(bus.frame_err), 0);
      chk("edge_cnt",    int'(bus.err_cnt), 3);
      send(8'h0A, 0);
      chk("edge_done", int'(bus.rx_msg_done), 1);
      chk("edge_val",  int'(bus.val_bin), 12);
      repeat (3) tick();

      send(8'h54, 0); send(8'h32, 0);
      rst_n = 1'b0;
      #1;
      chk("mrst_cmd",  int'(bus.chr_cmd), 0);
      chk("mrst_val",  int'(bus.val_bin), 0);
      chk("mrst_cnt",  int'(bus.err_cnt), 0);
      chk("mrst_done", int'(bus.rx_msg_done), 0);
      tick();
      rst_n = 1'b1;
      tick();
      send(8'h35, 0); send(8'h0A, 0);
      chk("mrst_lost", int'(bus.rx_msg_done), 0);

      for (int i = 0; i < 260; i++) begin
         send(8'h54, 0);
         send(8'h78, 0);
      end
      chk("sat_cnt", int'(bus.err_cnt), 255);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
